// File: rtl/gb_bcd_pkg.sv
// Shared types, constants and helpers for the packed-BCD add/sub datapath.
package gb_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] BCD_ADJ_LO   = 8'h06;
    localparam logic [7:0] BCD_ADJ_HI   = 8'h60;
    localparam logic [7:0] BCD_MAX_BYTE = 8'h99;

    // A nibble outside 0..9 is not a decimal digit.
    function automatic logic nibble_invalid(input logic [3:0] n);
        return n > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_addsub_seq_if.sv
// Request/response bundle for the sequential BCD adder/subtractor.
interface bcd_addsub_seq_if #(
    parameter int NUM_BYTES = 2
);
    logic                   start;
    logic                   sub;
    logic [8*NUM_BYTES-1:0] a;
    logic [8*NUM_BYTES-1:0] b;
    logic                   c_in;
    logic [8*NUM_BYTES-1:0] result;
    logic                   c_out;
    logic                   z_out;
    logic                   err;
    logic                   busy;
    logic                   done;

    modport master (
        output start, sub, a, b, c_in,
        input  result, c_out, z_out, err, busy, done
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output result, c_out, z_out, err, busy, done
    );
endinterface

// File: rtl/bcd_byte_step.sv
// One packed-BCD byte: binary add/sub with carry/borrow, then DAA-style correction.
module bcd_byte_step
    import gb_bcd_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cy,
    input  logic       sub,
    output logic [7:0] v,
    output logic       c,
    output logic       byte_err
);

    logic [8:0] s9;
    logic       h;
    logic [7:0] v_t;
    logic       c_t;

    // Binary step, half-carry recovered from bit 4, then decimal correction.
    always_comb begin
        if (sub) begin
            s9 = {1'b0, a_i} - {1'b0, b_i} - {8'h00, cy};
        end else begin
            s9 = {1'b0, a_i} + {1'b0, b_i} + {8'h00, cy};
        end
        // Bit 4 of the result is a4 ^ b4 ^ (carry/borrow into bit 4).
        h   = s9[4] ^ a_i[4] ^ b_i[4];
        v_t = s9[7:0];
        c_t = s9[8];
        if (!sub) begin
            // Upper-digit test uses the uncorrected value; +0x06 never sets carry.
            if (c_t || (v_t > BCD_MAX_BYTE)) begin
                v_t = v_t + BCD_ADJ_HI;
                c_t = 1'b1;
            end
            if (h || (v_t[3:0] > 4'd9)) begin
                v_t = v_t + BCD_ADJ_LO;
            end
        end else begin
            if (h) begin
                v_t = v_t - BCD_ADJ_LO;
            end
            if (c_t) begin
                v_t = v_t - BCD_ADJ_HI;
            end
        end
        v        = v_t;
        c        = c_t;
        byte_err = nibble_invalid(a_i[3:0]) | nibble_invalid(a_i[7:4]) |
                   nibble_invalid(b_i[3:0]) | nibble_invalid(b_i[7:4]);
    end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Multi-byte packed-BCD adder/subtractor, one byte per clock with rippled carry/borrow.
//
// state | meaning
// IDLE  | waiting for start; result/flags hold last values
// RUN   | processing byte idx_q, carry/borrow held in cy_q
// DONE  | done pulse cycle; start here begins the next op back-to-back
module bcd_addsub_seq
    import gb_bcd_pkg::*;
#(
    parameter int NUM_BYTES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    bcd_addsub_seq_if.slave  bus
);

    localparam int W     = 8 * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic             cy_q, cy_d;
    logic [W-1:0]     result_q, result_d;
    logic             c_out_q, c_out_d;
    logic             z_out_q, z_out_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0] a_i, b_i, step_v;
    logic       step_c, step_err;

    // Select the operand bytes addressed by the current index.
    always_comb begin
        a_i = '0;
        b_i = '0;
        for (int j = 0; j < NUM_BYTES; j++) begin
            if (idx_q == IDX_W'(j)) begin
                a_i = a_q[j*8 +: 8];
                b_i = b_q[j*8 +: 8];
            end
        end
    end

    bcd_byte_step u_step (
        .a_i      (a_i),
        .b_i      (b_i),
        .cy       (cy_q),
        .sub      (sub_q),
        .v        (step_v),
        .c        (step_c),
        .byte_err (step_err)
    );

    // Next-state, operand capture, result write-back and flag update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        cy_d     = cy_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        z_out_d  = z_out_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    sub_d    = bus.sub;
                    cy_d     = bus.c_in;
                    idx_d    = '0;
                    result_d = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int j = 0; j < NUM_BYTES; j++) begin
                    if (idx_q == IDX_W'(j)) begin
                        result_d[j*8 +: 8] = step_v;
                    end
                end
                cy_d  = step_c;
                err_d = err_q | step_err;
                if (idx_q == LAST_IDX) begin
                    c_out_d = step_c;
                    z_out_d = (result_d == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            cy_q     <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            z_out_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            z_out_q  <= z_out_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.z_out  = z_out_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Self-checking bench: directed cases plus random decimal operands against an integer model.
module tb_bcd_addsub_seq;

    localparam int NB = 2;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    bcd_addsub_seq_if #(.NUM_BYTES(NB)) bus ();

    bcd_addsub_seq #(.NUM_BYTES(NB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd_to_int(input logic [15:0] x);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference: four-digit arithmetic modulo 10000 with carry/borrow out.
    task automatic model(input logic s, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, output logic [15:0] r, output logic co);
        int x;
        if (s) x = bcd_to_int(av) - bcd_to_int(bv) - int'(ci);
        else   x = bcd_to_int(av) + bcd_to_int(bv) + int'(ci);
        co = (x < 0) || (x >= 10000);
        if (x < 0)           x += 10000;
        else if (x >= 10000) x -= 10000;
        r = int_to_bcd(x);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string tag, input logic s, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci, input bit poke,
                          input logic [15:0] exp_r, input logic exp_c, input logic exp_err);
        int n;
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = av;
        bus.b     = bv;
        bus.c_in  = ci;
        @(negedge clk);
        n = 1;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.start = poke;
        bus.sub   = ~s;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.c_in  = ~ci;
        while (!bus.done && n < 10) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
        end
        check({tag, "_latency"}, 32'(n), 32'(NB + 1));
        check({tag, "_result"}, 32'(bus.result), 32'(exp_r));
        check({tag, "_c_out"}, 32'(bus.c_out), 32'(exp_c));
        check({tag, "_z_out"}, 32'(bus.z_out), 32'(exp_r == 16'h0000));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    logic [15:0] er, ra, rb;
    logic        ec, rs, rc;

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", {27'd0, bus.c_out, bus.z_out, bus.err, bus.busy, bus.done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("add_ripple", 1'b0, 16'h1999, 16'h0001, 1'b0, 1'b0, 16'h2000, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("result_hold", 32'(bus.result), 32'h2000);

        run_op("add_wrap", 1'b0, 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        run_op("add_cin", 1'b0, 16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sub_borrow", 1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0, 16'h0999, 1'b0, 1'b0);
        @(negedge clk);
        run_op("sub_under", 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b0);
        @(negedge clk);
        // 0xA0+0x05: 0xA5 exceeds 0x99 -> +0x60 gives 0x05 with carry into byte 1.
        run_op("bad_bcd", 1'b0, 16'h00A0, 16'h0005, 1'b0, 1'b0, 16'h0105, 1'b0, 1'b1);
        @(negedge clk);
        run_op("err_clear", 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        run_op("start_busy", 1'b0, 16'h0500, 16'h0250, 1'b0, 1'b1, 16'h0750, 1'b0, 1'b0);
        run_op("back2back", 1'b1, 16'h0750, 16'h0251, 1'b0, 1'b0, 16'h0499, 1'b0, 1'b0);
        @(negedge clk);

        // Abort after byte 0 has been written.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 16'h1234;
        bus.b     = 16'h1111;
        bus.c_in  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_run_partial", 32'(bus.result[7:0]), 32'h45);
        reset_n = 1'b0;
        #1;
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_flags", {27'd0, bus.c_out, bus.z_out, bus.err, bus.busy, bus.done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        run_op("after_abort", 1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = int_to_bcd(int'($urandom_range(0, 9999)));
            rb = int_to_bcd(int'($urandom_range(0, 9999)));
            model(rs, ra, rb, rc, er, ec);
            run_op("rand", rs, ra, rb, rc, 1'($urandom_range(0, 1)), er, ec, 1'b0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
- Multi-byte packed-BCD adder/subtractor for the CPU execute path and timer/score helper logic; successor to the single-byte decimal-adjust block.
- Processes one byte (two BCD digits) per clock: binary add/sub, then Game Boy DAA correction.
- Ripples carry/borrow across cycles, so one instance handles any even digit count.
- Start/busy/done handshake, plus a non-BCD operand error flag the single-byte adjust does not have.

Parameters:
NUM_BYTES, 2, operand width in bytes (2 digits per byte); legal range 1..16
IDX_W, $clog2(NUM_BYTES) (min 1), width of the internal byte index; derived, not overridden

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
sub  in  1  0 = a+b+c_in, 1 = a-b-c_in (borrow); latched at accept
a  in  8*NUM_BYTES  minuend/addend, packed BCD, byte 0 least significant
b  in  8*NUM_BYTES  subtrahend/addend, packed BCD
c_in  in  1  initial carry/borrow into byte 0
result  out  8*NUM_BYTES  adjusted BCD result
c_out  out  1  final decimal carry (add) / borrow (sub)
z_out  out  1  result == 0
err  out  1  any nibble of latched a or b > 9
busy  out  1  operation in progress
done  out  1  one-cycle pulse when result/flags become valid

Behaviour:
- Reset (async, reset_n=0): state IDLE; result=0, c_out=0, z_out=0, err=0, busy=0, done=0; index=0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start: latch a, b, sub, c_in; carry reg = c_in; index=0; clear result/err; busy=1; go RUN.
  - DONE without start: back to IDLE after one cycle. result/flags hold in both states.
  - RUN: one byte per cycle, i = index.
    - Add: s = a_i + b_i + cy (9-bit). H = carry out of bit 3; C = s[8]; v = s[7:0]. If C or v>0x99: v += 0x60, C=1. If H or v[3:0]>9: v += 0x06. Sum truncated to 8 bits; C set only by the rule, never by the +0x06.
    - Sub: s = a_i - b_i - cy (9-bit two's complement). H = borrow from bit 4; C = borrow out of bit 7. If H: v -= 0x06. If C: v -= 0x60. C is unchanged by the correction.
    - Write result byte i = v; cy = C; err |= any nibble of a_i or b_i > 9.
    - If index == NUM_BYTES-1: c_out = C; z_out = (full result incl. this byte) == 0; busy=0; done=1 for this one cycle; go DONE. Else index++.
- Latency: start accepted at edge k; done=1 and outputs valid in the cycle after edge k+NUM_BYTES. Throughput: one op per NUM_BYTES+1 cycles; start in DONE gives back-to-back ops.
- start while busy=1: ignored; latched operands untouched.
- Operand ports may change after accept without effect.
- err is informational; computation still completes with DAA-defined bytes.
- Reset mid-RUN: immediate abort to reset values; no done.
- NUM_BYTES=1: single RUN cycle; equivalent to byte add/sub followed by DAA.

Decomposition:
- Shared package gb_bcd_pkg:
  - state enum (IDLE, RUN, DONE)
  - constants BCD_ADJ_LO=8'h06, BCD_ADJ_HI=8'h60, BCD_MAX_BYTE=8'h99
  - function nibble_invalid(4-bit)
- One combinational sub-module bcd_byte_step handles a single byte:
  - inputs: a_i, b_i, cy, sub
  - outputs: v, C, byte_err
- The top level holds the FSM, index counter, operand/result registers and the flag logic.

Test Plan:
- NUM_BYTES=2, sub=0, a=0x1999, b=0x0001, c_in=0 -> result 0x2000, c_out=0, z_out=0, err=0, done exactly 3 cycles after accept.
- sub=0, a=0x9999, b=0x0001 -> result 0x0000, c_out=1, z_out=1; with c_in=1 and b=0x0000 -> same result.
- sub=1, a=0x1000, b=0x0001 -> 0x0999, c_out=0; a=0x0000, b=0x0001 -> 0x9999, c_out=1, z_out=0.
- a=0x00A0, b=0x0005, sub=0 -> err=1, done still pulses; a following op with valid BCD -> err=0.
- Pulse start again 1 cycle after accept with different operands -> ignored; first result unchanged. start held in DONE -> second op accepted, done 3 cycles later.
- Drop reset_n mid-RUN (after byte 0) -> outputs immediately 0, busy=0, no done; a subsequent op completes correctly.
